mmio_store_sink: RTL

Bus target for CPU data-memory stores. It decodes MemWrite/DataAdr/WriteData against a fixed address window and buffers accepted stores in a small FIFO. Each buffered 32-bit word drains as four 8-bit writes into the VGA framebuffer write port. It sits between the CPU store path and the framebuffer RAM, which arbitrates against VGA scan-out through fb_ready.

---
 rtl/mmio_store_sink_pkg.sv | 22 ++
 rtl/mmio_store_sink_if.sv | 29 ++
 rtl/mmio_store_sink_fifo.sv | 61 ++++++
 rtl/mmio_store_sink.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mmio_store_sink_pkg.sv
// mmio_pkg: shared types and constants for the MMIO store sink.
// Holds the drain FSM state encoding, the buffered store-entry layout,
// the byte count per word and the default window base address.
package mmio_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_1000;

  // Drain FSM states; the top mirrors these as plain localparam constants.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // One buffered store: window byte offset plus the stored word.
  // The offset is kept 32 bits wide so the type is independent of FB_AW.
  typedef struct packed {
    logic [31:0] offset;
    logic [31:0] data;
  } store_entry_t;

endpackage : mmio_pkg

// File: rtl/mmio_store_sink_if.sv
// mmio_store_sink_if: CPU store port and framebuffer write port of the sink.
// master = CPU/framebuffer side (drives stores and fb_ready),
// slave  = the sink itself.
interface mmio_store_sink_if #(
  parameter int FB_AW = 10
);

  logic             MemWrite;
  logic [31:0]      DataAdr;
  logic [31:0]      WriteData;
  logic             stall;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_data;
  logic             fb_ready;
  logic             busy;
  logic             err_sticky;

  modport master (
    output MemWrite, DataAdr, WriteData, fb_ready,
    input  stall, fb_we, fb_addr, fb_data, busy, err_sticky
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, fb_ready,
    output stall, fb_we, fb_addr, fb_data, busy, err_sticky
  );

endinterface : mmio_store_sink_if

// File: rtl/mmio_store_sink_fifo.sv
// sync_fifo: single-clock show-ahead FIFO used as the store buffer.
// rd_data always presents the oldest entry; push is ignored when full and
// pop is ignored when empty. Synchronous active-low reset empties it.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array is deliberately not reset; only pointers and count
  // define validity, and leaving it out keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^AW.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/mmio_store_sink.sv
// mmio_store_sink: decodes CPU stores against a word window, buffers aligned
// hits in a small FIFO and drains each word as four byte writes to the
// framebuffer port, holding each byte until fb_ready.
// Optional macro BIG_ENDIAN_EN: lane n emits WriteData[8*(3-n)+:8] instead of
// WriteData[8*n+:8]; addresses and timing are unchanged.
module mmio_store_sink
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int          WINDOW_WORDS = 256,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          FB_AW        = $clog2(4 * WINDOW_WORDS)
) (
  input  logic               clk,
  input  logic               reset,
  mmio_store_sink_if.slave   bus
);

  localparam int          CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int          ENT_W  = FB_AW + 32;
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(BYTES_PER_WORD * WINDOW_WORDS);

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_EMIT = 1'(EMIT);

  // Address decode; 33-bit compare so a window touching 2^32 cannot wrap.
  logic hit;
  logic aligned_hit;
  logic misaligned;
  logic push;
  logic drop;
  logic [ENT_W-1:0] push_entry;

  assign hit         = bus.MemWrite
                       && ({1'b0, bus.DataAdr} >= WIN_LO)
                       && ({1'b0, bus.DataAdr} <  WIN_HI);
  assign aligned_hit = hit && (bus.DataAdr[1:0] == 2'b00);
  assign misaligned  = hit && (bus.DataAdr[1:0] != 2'b00);
  assign push_entry  = {FB_AW'(bus.DataAdr - BASE_ADDR), bus.WriteData};

  // Store buffer.
  logic [ENT_W-1:0] fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;

  // Fullness is the registered count, so a same-cycle pop never frees a slot.
  assign push = aligned_hit && !fifo_full;
  assign drop = aligned_hit &&  fifo_full;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Drain FSM state.
  logic [0:0]       state;
  logic [1:0]       lane;
  store_entry_t     hold;
  store_entry_t     head;
  logic             fb_we_q;
  logic [FB_AW-1:0] fb_addr_q;
  logic [7:0]       fb_data_q;
  logic             err_q;

  // Byte lane selection; the only place endianness matters.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] n);
`ifdef BIG_ENDIAN_EN
    return w[8 * (3 - int'(n)) +: 8];
`else
    return w[8 * int'(n) +: 8];
`endif
  endfunction

  // Unpack the FIFO head and decide whether the FSM takes it this cycle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    head        = '0;
    head.offset = 32'(fifo_rd[ENT_W-1:32]);
    head.data   = fifo_rd[31:0];
    pop         = 1'b0;
    if (!fifo_empty) begin
      if (state == ST_IDLE)
        pop = 1'b1;
      else if (bus.fb_ready && (lane == 2'd3))
        pop = 1'b1;
    end
  end

  // Drain sequencing: load a word on pop, step lanes on fb_ready,
  // and keep the registered framebuffer outputs stable otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lane      <= 2'd0;
      hold      <= '0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else if (pop) begin
      state     <= ST_EMIT;
      lane      <= 2'd0;
      hold      <= head;
      fb_we_q   <= 1'b1;
      fb_addr_q <= FB_AW'(head.offset);
      fb_data_q <= pick_byte(head.data, 2'd0);
    end else if ((state == ST_EMIT) && bus.fb_ready) begin
      if (lane != 2'd3) begin
        lane      <= lane + 2'd1;
        fb_addr_q <= FB_AW'(hold.offset + 32'(lane) + 32'd1);
        fb_data_q <= pick_byte(hold.data, lane + 2'd1);
      end else begin
        state   <= ST_IDLE;
        fb_we_q <= 1'b0;
      end
    end
  end

  // Sticky error for misaligned or dropped in-window stores.
  always_ff @(posedge clk) begin
    if (!reset)
      err_q <= 1'b0;
    else if (misaligned || drop)
      err_q <= 1'b1;
  end

  assign bus.stall      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.busy       = !fifo_empty || (state != ST_IDLE);
  assign bus.err_sticky = err_q;

endmodule : mmio_store_sink
